// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, FSM states and the letter pattern table.
// Patterns are right-aligned with the first element in the highest used bit (dot=0, dash=1).
package morse_pkg;

    typedef enum logic [4:0] {
        LTR_NONE = 5'd0,
        LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H, LTR_I,
        LTR_J, LTR_K, LTR_L, LTR_M, LTR_N, LTR_O, LTR_P, LTR_Q, LTR_R,
        LTR_S, LTR_T, LTR_U, LTR_V, LTR_W, LTR_X, LTR_Y, LTR_Z
    } letter_t;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        FLUSH
    } state_e;

    localparam int NUM_LETTERS = 26;
    localparam logic [2:0] MAX_ELEMS = 3'd4;

    // Entry i describes letter code i+1 (A..Z).
    localparam logic [3:0] LETTER_PAT [NUM_LETTERS] = '{
        4'b0001, 4'b1000, 4'b1010, 4'b0100, 4'b0000, 4'b0010, 4'b0110,
        4'b0000, 4'b0000, 4'b0111, 4'b0101, 4'b0100, 4'b0011, 4'b0010,
        4'b0111, 4'b0110, 4'b1101, 4'b0010, 4'b0000, 4'b0001, 4'b0001,
        4'b0001, 4'b0011, 4'b1001, 4'b1011, 4'b1100
    };

    localparam logic [2:0] LETTER_LEN [NUM_LETTERS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3,
        3'd4, 3'd2, 3'd4, 3'd3, 3'd4, 3'd2, 3'd2,
        3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd3,
        3'd4, 3'd3, 3'd4, 3'd4, 3'd4
    };

endpackage

// File: rtl/morse_symbol_lookup.sv
// Combinational match of a collected element pattern against the A..Z table.
module morse_symbol_lookup
    import morse_pkg::*;
(
    input  logic [3:0] pattern_i,
    input  logic [2:0] count_i,
    output logic       valid_o,
    output letter_t    code_o
);

    always_comb begin
        valid_o = 1'b0;
        code_o  = LTR_NONE;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (count_i == LETTER_LEN[i] && pattern_i == LETTER_PAT[i]) begin
                valid_o = 1'b1;
                code_o  = letter_t'(5'(i + 1));
            end
        end
    end

endmodule

// File: rtl/morse_code_decryptor.sv
// Serial Morse decoder: measures mark/space runs, collects up to four elements per letter
// and emits a registered VALID or ERR pulse when GAP_LEN consecutive low samples close the letter.
module morse_code_decryptor
    import morse_pkg::*;
#(
    parameter int GAP_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic       IN,
    output logic [4:0] OUT,
    output logic       VALID,
    output logic       ERR
);

    localparam logic [2:0] GAP = 3'(GAP_LEN);

    state_e     state_q, state_d;
    logic [2:0] run_q, run_d;
    logic [2:0] elem_q, elem_d;
    logic [2:0] zero_q, zero_d;
    logic [3:0] pattern_q, pattern_d;
    letter_t    out_q, out_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic       lookupValid;
    letter_t    lookupCode;

    morse_symbol_lookup u_lookup (
        .pattern_i (pattern_q),
        .count_i   (elem_q),
        .valid_o   (lookupValid),
        .code_o    (lookupCode)
    );

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        elem_d    = elem_q;
        zero_d    = zero_q;
        pattern_d = pattern_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (!EN) begin
            state_d   = IDLE;
            run_d     = 3'd0;
            elem_d    = 3'd0;
            zero_d    = 3'd0;
            pattern_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN) begin
                        state_d   = MARK;
                        run_d     = 3'd1;
                        elem_d    = 3'd0;
                        zero_d    = 3'd0;
                        pattern_d = 4'd0;
                    end
                end

                MARK: begin
                    if (IN) begin
                        if (run_q != 3'd7) begin
                            run_d = run_q + 3'd1;
                        end
                    end else if (run_q >= 3'd5 || elem_q == MAX_ELEMS) begin
                        // Overlong mark or a fifth element: wait out the letter, then report it once.
                        state_d = FLUSH;
                        zero_d  = 3'd1;
                    end else begin
                        state_d   = SPACE;
                        pattern_d = {pattern_q[2:0], run_q >= 3'd3};
                        elem_d    = elem_q + 3'd1;
                        zero_d    = 3'd1;
                    end
                end

                SPACE: begin
                    if (IN) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                        zero_d  = 3'd0;
                    end else if (zero_q + 3'd1 == GAP) begin
                        state_d   = IDLE;
                        run_d     = 3'd0;
                        elem_d    = 3'd0;
                        zero_d    = 3'd0;
                        pattern_d = 4'd0;
                        if (lookupValid) begin
                            valid_d = 1'b1;
                            out_d   = lookupCode;
                        end else begin
                            err_d = 1'b1;
                            out_d = LTR_NONE;
                        end
                    end else begin
                        zero_d = zero_q + 3'd1;
                    end
                end

                FLUSH: begin
                    if (IN) begin
                        zero_d = 3'd0;
                    end else if (zero_q + 3'd1 == GAP) begin
                        state_d   = IDLE;
                        run_d     = 3'd0;
                        elem_d    = 3'd0;
                        zero_d    = 3'd0;
                        pattern_d = 4'd0;
                        err_d     = 1'b1;
                        out_d     = LTR_NONE;
                    end else begin
                        zero_d = zero_q + 3'd1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_q     <= 3'd0;
            elem_q    <= 3'd0;
            zero_q    <= 3'd0;
            pattern_q <= 4'd0;
            out_q     <= LTR_NONE;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            elem_q    <= elem_d;
            zero_q    <= zero_d;
            pattern_q <= pattern_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign OUT   = out_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_morse_code_decryptor.sv
// Directed self-checking bench for morse_code_decryptor with default GAP_LEN of 3.
module tb_morse_code_decryptor;

    logic       clk;
    logic       rst;
    logic       EN;
    logic       IN;
    logic [4:0] OUT;
    logic       VALID;
    logic       ERR;

    int testsRun;
    int failures;
    int validCount;
    int errCount;
    int bothHigh;
    int codeLog [8];

    morse_code_decryptor #(.GAP_LEN(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .EN    (EN),
        .IN    (IN),
        .OUT   (OUT),
        .VALID (VALID),
        .ERR   (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor samples just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (VALID) begin
            if (validCount < 8) codeLog[validCount] = int'(OUT);
            validCount++;
        end
        if (ERR) errCount++;
        if (VALID && ERR) bothHigh++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic in);
        @(negedge clk);
        EN = en;
        IN = in;
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(1'b1, s[i] == "1");
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic clearMonitor();
        validCount = 0;
        errCount   = 0;
        for (int i = 0; i < 8; i++) codeLog[i] = -1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun = 0;
        failures = 0;
        bothHigh = 0;
        clearMonitor();
        rst = 1'b1;
        EN  = 1'b1;
        IN  = 1'b1;

        // Reset dominates EN and IN.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out", int'(OUT), 0);
        checkOutput("reset_valid", int'(VALID), 0);
        checkOutput("reset_err", int'(ERR), 0);
        @(negedge clk);
        rst = 1'b0;
        IN  = 1'b0;
        drain(2);

        // Letter A with exact pulse timing.
        sendString("1011100");
        @(posedge clk);
        #1;
        checkOutput("A_early_valid", int'(VALID), 0);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("A_valid", int'(VALID), 1);
        checkOutput("A_out", int'(OUT), 1);
        checkOutput("A_err", int'(ERR), 0);
        @(posedge clk);
        #1;
        checkOutput("A_pulse_end", int'(VALID), 0);
        checkOutput("A_out_hold", int'(OUT), 1);

        // Q with stretched final dash.
        drain(2);
        clearMonitor();
        sendString("11101110101111000");
        drain(3);
        checkOutput("Q_valid_cnt", validCount, 1);
        checkOutput("Q_code", codeLog[0], 17);
        checkOutput("Q_err_cnt", errCount, 0);

        // I with both dots stretched to two cycles.
        clearMonitor();
        sendString("11011000");
        drain(3);
        checkOutput("I_valid_cnt", validCount, 1);
        checkOutput("I_code", codeLog[0], 9);

        // E then T back-to-back.
        clearMonitor();
        sendString("1000111000");
        drain(3);
        checkOutput("ET_valid_cnt", validCount, 2);
        checkOutput("ET_err_cnt", errCount, 0);
        checkOutput("ET_code0", codeLog[0], 5);
        checkOutput("ET_code1", codeLog[1], 20);

        // Overlong mark, then H.
        clearMonitor();
        sendString("11111000");
        drain(3);
        checkOutput("long_err_cnt", errCount, 1);
        checkOutput("long_valid_cnt", validCount, 0);
        checkOutput("long_out", int'(OUT), 0);
        clearMonitor();
        sendString("1010101000");
        drain(3);
        checkOutput("H_valid_cnt", validCount, 1);
        checkOutput("H_code", codeLog[0], 8);

        // Five dots.
        clearMonitor();
        sendString("101010101000");
        drain(3);
        checkOutput("five_err_cnt", errCount, 1);
        checkOutput("five_valid_cnt", validCount, 0);
        checkOutput("five_out", int'(OUT), 0);

        // Unused four-element pattern ..--
        clearMonitor();
        sendString("10101110111000");
        drain(3);
        checkOutput("unused_err_cnt", errCount, 1);
        checkOutput("unused_valid_cnt", validCount, 0);

        // High sample during flush restarts the closing gap.
        clearMonitor();
        sendString("11111001");
        drain(1);
        checkOutput("flush_no_early_err", errCount, 0);
        drain(5);
        checkOutput("flush_err_cnt", errCount, 1);

        // EN drop after "-." discards the letter, then N decodes.
        clearMonitor();
        sendString("11101");
        repeat (4) applyStimulus(1'b0, 1'b0);
        sendString("11101000");
        drain(3);
        checkOutput("en_abort_valid_cnt", validCount, 1);
        checkOutput("en_abort_err_cnt", errCount, 0);
        checkOutput("en_abort_code", codeLog[0], 14);

        // Reset mid-letter discards it and clears OUT.
        clearMonitor();
        sendString("1110");
        @(negedge clk);
        rst = 1'b1;
        EN  = 1'b1;
        IN  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_out", int'(OUT), 0);
        @(negedge clk);
        rst = 1'b0;
        IN  = 1'b0;
        sendString("11101000");
        drain(3);
        checkOutput("rst_abort_valid_cnt", validCount, 1);
        checkOutput("rst_abort_err_cnt", errCount, 0);
        checkOutput("rst_abort_code", codeLog[0], 14);

        // EN rising while IN is already high counts that sample as the first mark cycle.
        clearMonitor();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        sendString("000");
        drain(3);
        checkOutput("en_high_valid_cnt", validCount, 1);
        checkOutput("en_high_code", codeLog[0], 5);

        checkOutput("valid_err_overlap", bothHigh, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/morse_code_decryptor.md
MORSE_CODE_DECRYPTOR -- requirements
Module: morse_code_decryptor

Interface
REQ-001 Parameter GAP_LEN, default 3: consecutive low samples that end a letter; legal range 2..7.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 EN  input  1  decode enable; IN is sampled only while EN=1.
REQ-005 IN  input  1  serial Morse line, one sample per clk: dot = 1 high cycle, dash = 3 high cycles, element gap = 1 low cycle.
REQ-006 OUT  output  5  decoded letter code: A=1 .. Z=26, 0 = none/error.
REQ-007 VALID  output  1  one-cycle pulse; OUT carries a newly decoded letter.
REQ-008 ERR  output  1  one-cycle pulse; the letter just closed was malformed.

Function
REQ-009 FSM states SHALL be: IDLE, MARK, SPACE, FLUSH.
REQ-010 IDLE: IN=0 ignored; IN=1 -> MARK, run counter=1, element count=0, pattern cleared.
REQ-011 MARK: each IN=1 increments the 3-bit run counter, saturating at 7.
REQ-012 MARK, IN=0: run 1..2 appends dot (0); run 3..4 appends dash (1); run >=5 -> FLUSH.
REQ-013 Run tolerance: a dot stretched to 2 cycles or a dash stretched to 4 cycles SHALL decode normally.
REQ-014 On a legal MARK exit, the element is shifted into the 4-bit pattern (first element MSB-first), element count +1, zero counter=1, next state SPACE.
REQ-015 A 5th element SHALL send the FSM to FLUSH instead of being stored.
REQ-016 SPACE: IN=1 before GAP_LEN zeros -> MARK with run counter=1 (intra-letter gap).
REQ-017 SPACE: the edge sampling the GAP_LEN-th consecutive zero SHALL close the letter and return to IDLE.
REQ-018 Letter close with a valid pattern/count: VALID=1 and OUT=code in the next cycle (registered at the closing edge).
REQ-019 Letter close with a pattern not among A..Z (e.g. 4-element ..--): ERR=1 and OUT=0 in the next cycle.
REQ-020 FLUSH: IN=1 resets the zero counter; GAP_LEN consecutive zeros -> ERR pulse, OUT=0, IDLE; exactly one ERR per malformed letter.
REQ-021 OUT SHALL hold its last value between pulses; VALID and ERR are never high together.
REQ-022 EN=0 in any state: discard the partial letter, go to IDLE, no pulse; counters are cleared.
REQ-023 EN=1 with IN already high: the first sampled high counts as run cycle 1.
REQ-024 Throughput: back-to-back letters separated by exactly GAP_LEN zeros SHALL all decode; no dead cycles required.

Reset
REQ-025 rst=1 at a clock edge: state=IDLE, OUT=0, VALID=0, ERR=0, all counters and the pattern=0.
REQ-026 Reset mid-letter SHALL discard the letter with no VALID/ERR; rst dominates EN and IN.

Structure
REQ-027 Shared package morse_pkg SHALL hold: letter codes A..Z (1..26), a 5-bit letter typedef, the FSM state enum, and the 26-entry pattern/length table shared with the encoder.
REQ-028 One combinational sub-module morse_symbol_lookup SHALL map (4-bit pattern, 3-bit count) to {valid, 5-bit code}.
REQ-029 Counters SHALL be 3 bits wide; no arithmetic wider than 3 bits.

Verification
REQ-030 "A": EN=1, IN=1,0,1,1,1,0,0,0 -> VALID pulse with OUT=1 one cycle after the 3rd zero; no ERR.
REQ-031 "Q" with a stretched final dash: IN=111,0,111,0,1,0,1111,000 -> VALID with OUT=17.
REQ-032 "E T" back-to-back: IN=1,000,111,000 -> VALID OUT=5, then VALID OUT=20; exactly 2 pulses.
REQ-033 Malformed: a high run of 5 followed by 000 -> a single ERR, OUT=0; then "....",000 -> VALID OUT=8.
REQ-034 Five dots ".....",000 -> one ERR; the unused pattern "..--",000 -> one ERR.
REQ-035 Abort: EN drops after "-." of a letter, or rst pulses mid-letter -> no VALID/ERR; a following "N" decodes as OUT=14.
